mc_controller: RTL and testbench



---
 rtl/mc_controller_pkg.sv | 68 ++++++
 rtl/condcheck.sv | 40 ++++
 rtl/mc_controller.sv | 177 +++++++++++++++++
 tb/tb_mc_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: shared types and encodings for the multicycle ARM-subset
// control unit.
//   state_t        Moore controller states
//   ALU_*          ALUControl codes
//   CMD_*          data-processing cmd field values (Funct[4:1])
//   OP_*           Op field values
//   SRCA_*/SRCB_*  ALU operand select encodings
//   RES_*          ResultSrc encodings
//   COND_*         condition field codes
package mc_controller_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMRD,
      MEMWB,
      MEMWR,
      EXECUTER,
      EXECUTEI,
      ALUWB,
      BRANCH,
      UNKNOWN
   } state_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [1:0] SRCA_REG = 2'b00;
   localparam logic [1:0] SRCA_PC  = 2'b01;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/condcheck.sv
// condcheck: evaluates an ARM condition field against the NZCV flags.
//   Cond    in  4  condition field
//   Flags   in  4  {N,Z,C,V}
//   CondEx  out 1  1 when the instruction should execute
module condcheck
   import mc_controller_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic n, z, c, v, ge;

   assign {n, z, c, v} = Flags;
   assign ge = (n == v);

   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         COND_EQ: CondEx = z;
         COND_NE: CondEx = ~z;
         COND_CS: CondEx = c;
         COND_CC: CondEx = ~c;
         COND_MI: CondEx = n;
         COND_PL: CondEx = ~n;
         COND_VS: CondEx = v;
         COND_VC: CondEx = ~v;
         COND_HI: CondEx = c & ~z;
         COND_LS: CondEx = ~c | z;
         COND_GE: CondEx = ge;
         COND_LT: CondEx = ~ge;
         COND_GT: CondEx = ~z & ge;
         COND_LE: CondEx = z | ~ge;
         COND_AL: CondEx = 1'b1;
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for the ARM-subset processor.
// Moore FSM sequencing the shared memory/ALU datapath, NZCV flag register and
// condition gating of all architectural writes.
//   clk, reset                      clock, synchronous active-high reset
//   Cond, Op, Funct, Rd             instruction fields from the IR
//   ALUFlags                        {N,Z,C,V} from the ALU this cycle
//   PCWrite/MemWrite/RegWrite/IRWrite  write enables (forced 0 in reset)
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc  datapath mux selects
//   ImmSrc, RegSrc                  Op-derived decode
//   ALUControl                      ALU operation
module mc_controller
   import mc_controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic [1:0] ALUControl
);

   state_t     state, state_next;
   logic [3:0] flags;
   logic [3:0] cmd;
   logic       cond_raw, cond_ex, cond_ex_l;
   logic       next_pc, branch, reg_w, mem_w, alu_op, ir_w;
   logic       pcs;
   logic [1:0] flag_w;

   assign cmd = Funct[4:1];

   condcheck u_condcheck (
      .Cond   (Cond),
      .Flags  (flags),
      .CondEx (cond_raw)
   );

   // The never-execute code is suppressed here regardless of what the checker returns.
   assign cond_ex = cond_raw & (Cond != COND_NV);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = FETCH;
      case (state)
         FETCH:  state_next = DECODE;
         DECODE: begin
            case (Op)
               OP_DP:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
               OP_MEM:  state_next = MEMADR;
               OP_BR:   state_next = BRANCH;
               default: state_next = UNKNOWN;
            endcase
         end
         MEMADR:   state_next = Funct[0] ? MEMRD : MEMWR;
         MEMRD:    state_next = MEMWB;
         EXECUTER: state_next = ALUWB;
         EXECUTEI: state_next = ALUWB;
         default:  state_next = FETCH;
      endcase
   end

   // Raw Moore controls, before condition gating
   always_comb begin
      next_pc   = 1'b0;
      branch    = 1'b0;
      reg_w     = 1'b0;
      mem_w     = 1'b0;
      alu_op    = 1'b0;
      ir_w      = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = SRCA_REG;
      ALUSrcB   = SRCB_REG;
      ResultSrc = RES_ALUOUT;
      case (state)
         FETCH: begin
            ir_w      = 1'b1;
            next_pc   = 1'b1;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
         end
         DECODE: begin
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
         end
         MEMADR: ALUSrcB = SRCB_IMM;
         MEMRD:  AdrSrc  = 1'b1;
         MEMWR: begin
            AdrSrc = 1'b1;
            mem_w  = 1'b1;
         end
         MEMWB: begin
            ResultSrc = RES_DATA;
            reg_w     = 1'b1;
         end
         EXECUTER: begin
            alu_op  = 1'b1;
            ALUSrcB = SRCB_REG;
         end
         EXECUTEI: begin
            alu_op  = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         ALUWB: reg_w = 1'b1;
         BRANCH: begin
            branch    = 1'b1;
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALURESULT;
         end
         default: ;
      endcase
   end

   // ALU decode
   always_comb begin
      ALUControl = ALU_ADD;
      if (alu_op) begin
         case (cmd)
            CMD_ADD: ALUControl = ALU_ADD;
            CMD_SUB: ALUControl = ALU_SUB;
            CMD_AND: ALUControl = ALU_AND;
            CMD_ORR: ALUControl = ALU_ORR;
            default: ALUControl = ALU_ADD;
         endcase
      end
   end

   // N,Z follow any S-suffixed op; C,V only arithmetic ones
   assign flag_w[1] = alu_op & Funct[0];
   assign flag_w[0] = flag_w[1] & ((cmd == CMD_ADD) | (cmd == CMD_SUB));

   // Condition is latched once per instruction so later flag writes in the
   // same instruction cannot change whether it executes.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags     <= '0;
         cond_ex_l <= 1'b0;
      end else begin
         if (state == DECODE)
            cond_ex_l <= cond_ex;
         if (flag_w[1] & cond_ex_l)
            flags[3:2] <= ALUFlags[3:2];
         if (flag_w[0] & cond_ex_l)
            flags[1:0] <= ALUFlags[1:0];
      end
   end

   assign pcs = ((Rd == 4'd15) & reg_w) | branch;

   assign PCWrite  = ~reset & (next_pc | (pcs & cond_ex_l));
   assign RegWrite = ~reset & reg_w & cond_ex_l;
   assign MemWrite = ~reset & mem_w & cond_ex_l;
   assign IRWrite  = ~reset & ir_w;

   assign ImmSrc = Op;
   assign RegSrc = {Op == OP_MEM, Op == OP_BR};

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: per-cycle vector table for mc_controller. Each record holds
// the instruction fields, ALUFlags and the hand-derived control word for one
// cycle; multi-cycle instruction sequences are laid out back to back.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond, Rd, ALUFlags;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

   always #5 clk = ~clk;

   mc_controller dut (
      .clk        (clk),
      .reset      (reset),
      .Cond       (Cond),
      .Op         (Op),
      .Funct      (Funct),
      .Rd         (Rd),
      .ALUFlags   (ALUFlags),
      .PCWrite    (PCWrite),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .IRWrite    (IRWrite),
      .AdrSrc     (AdrSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .ALUControl (ALUControl)
   );

   // Control word: {PCW,MW,RW,IRW, AdrSrc, SrcA, SrcB, ResultSrc, ALUControl, ImmSrc, RegSrc}
   typedef struct {
      string       tag;
      logic        rst;
      logic [3:0]  cond;
      logic [1:0]  op;
      logic [5:0]  funct;
      logic [3:0]  rd;
      logic [3:0]  af;
      logic [16:0] exp;
      logic [16:0] mask;
      logic        chk_flags;
      logic [3:0]  exp_flags;
   } vec_t;

   vec_t vecs[$];

   logic [3:0] c_cond, c_rd;
   logic [1:0] c_op, c_imm, c_rsrc;
   logic [5:0] c_funct;

   int checks = 0;
   int errors = 0;

   function automatic void ctx(input logic [3:0] cond, input logic [1:0] op,
                               input logic [5:0] funct, input logic [3:0] rd,
                               input logic [1:0] imm, input logic [1:0] rsrc);
      c_cond = cond; c_op = op; c_funct = funct; c_rd = rd;
      c_imm = imm; c_rsrc = rsrc;
   endfunction

   function automatic void pv(input string tag, input logic rst, input logic en_only,
                              input logic [3:0] af, input logic [3:0] en, input logic adr,
                              input logic [1:0] sa, input logic [1:0] sb,
                              input logic [1:0] rs, input logic [1:0] ac);
      vec_t v;
      v.tag = tag; v.rst = rst; v.cond = c_cond; v.op = c_op; v.funct = c_funct;
      v.rd = c_rd; v.af = af;
      v.exp = {en, adr, sa, sb, rs, ac, c_imm, c_rsrc};
      v.mask = en_only ? 17'h1E000 : 17'h1FFFF;
      v.chk_flags = 1'b0; v.exp_flags = 4'h0;
      vecs.push_back(v);
   endfunction

   function automatic void cf(input logic [3:0] f);
      vec_t v;
      v = vecs.pop_back();
      v.chk_flags = 1'b1; v.exp_flags = f;
      vecs.push_back(v);
   endfunction

   logic [16:0] got;

   initial begin
      // ADD r1 under reset, then executed
      ctx(4'hE, 2'b00, 6'b001000, 4'd1, 2'b00, 2'b00);
      pv("rst0",       1, 1, 4'h0, 4'b0000, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("rst1",       1, 0, 4'h0, 4'b0000, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("add.fetch",  0, 0, 4'h0, 4'b1001, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("add.decode", 0, 0, 4'h0, 4'b0000, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("add.exec",   0, 0, 4'h0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      pv("add.wb",     0, 0, 4'h0, 4'b0010, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      cf(4'b0000);
      // SUBS r2, ALU reports Z
      ctx(4'hE, 2'b00, 6'b000101, 4'd2, 2'b00, 2'b00);
      pv("subs.fetch", 0, 0, 4'h0, 4'b1001, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("subs.decode",0, 0, 4'h0, 4'b0000, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("subs.exec",  0, 0, 4'b0100, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 2'b01);
      pv("subs.wb",    0, 0, 4'h0, 4'b0010, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      cf(4'b0100);
      // BEQ taken (Z=1)
      ctx(4'h0, 2'b10, 6'b000000, 4'd0, 2'b10, 2'b01);
      pv("beq.fetch",  0, 0, 4'h0, 4'b1001, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("beq.decode", 0, 0, 4'h0, 4'b0000, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("beq.branch", 0, 0, 4'h0, 4'b1000, 0, 2'b00, 2'b01, 2'b10, 2'b00);
      // BNE not taken (Z=1)
      ctx(4'h1, 2'b10, 6'b000000, 4'd0, 2'b10, 2'b01);
      pv("bne.fetch",  0, 0, 4'h0, 4'b1001, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("bne.decode", 0, 0, 4'h0, 4'b0000, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("bne.branch", 0, 0, 4'h0, 4'b0000, 0, 2'b00, 2'b01, 2'b10, 2'b00);
      // LDR r3
      ctx(4'hE, 2'b01, 6'b011001, 4'd3, 2'b01, 2'b10);
      pv("ldr.fetch",  0, 0, 4'h0, 4'b1001, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("ldr.decode", 0, 0, 4'h0, 4'b0000, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("ldr.memadr", 0, 0, 4'h0, 4'b0000, 0, 2'b00, 2'b01, 2'b00, 2'b00);
      pv("ldr.memrd",  0, 0, 4'h0, 4'b0000, 1, 2'b00, 2'b00, 2'b00, 2'b00);
      pv("ldr.memwb",  0, 0, 4'h0, 4'b0010, 0, 2'b00, 2'b00, 2'b01, 2'b00);
      // STR r4
      ctx(4'hE, 2'b01, 6'b011000, 4'd4, 2'b01, 2'b10);
      pv("str.fetch",  0, 0, 4'h0, 4'b1001, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("str.decode", 0, 0, 4'h0, 4'b0000, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("str.memadr", 0, 0, 4'h0, 4'b0000, 0, 2'b00, 2'b01, 2'b00, 2'b00);
      pv("str.memwr",  0, 0, 4'h0, 4'b0100, 1, 2'b00, 2'b00, 2'b00, 2'b00);
      // ADDS sets C,V; clears N,Z
      ctx(4'hE, 2'b00, 6'b001001, 4'd5, 2'b00, 2'b00);
      pv("adds.fetch", 0, 0, 4'h0, 4'b1001, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("adds.decode",0, 0, 4'h0, 4'b0000, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("adds.exec",  0, 0, 4'b0011, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      pv("adds.wb",    0, 0, 4'h0, 4'b0010, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      cf(4'b0011);
      // ORRS immediate: only N,Z written, C,V retained
      ctx(4'hE, 2'b00, 6'b111001, 4'd6, 2'b00, 2'b00);
      pv("orrs.fetch", 0, 0, 4'h0, 4'b1001, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("orrs.decode",0, 0, 4'h0, 4'b0000, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("orrs.exec",  0, 0, 4'b1000, 4'b0000, 0, 2'b00, 2'b01, 2'b00, 2'b11);
      pv("orrs.wb",    0, 0, 4'h0, 4'b0010, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      cf(4'b1011);
      // ANDSEQ with Z=0: condition fails, no register or flag write
      ctx(4'h0, 2'b00, 6'b000001, 4'd7, 2'b00, 2'b00);
      pv("ands.fetch", 0, 0, 4'h0, 4'b1001, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("ands.decode",0, 0, 4'h0, 4'b0000, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("ands.exec",  0, 0, 4'b0100, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 2'b10);
      pv("ands.wb",    0, 0, 4'h0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      cf(4'b1011);
      // ADD to PC (Rd=15): writeback also writes PC
      ctx(4'hE, 2'b00, 6'b001000, 4'd15, 2'b00, 2'b00);
      pv("addpc.fetch",0, 0, 4'h0, 4'b1001, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("addpc.decode",0,0, 4'h0, 4'b0000, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("addpc.exec", 0, 0, 4'h0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      pv("addpc.wb",   0, 0, 4'h0, 4'b1010, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      // Op=11 undefined
      ctx(4'hE, 2'b11, 6'b000000, 4'd0, 2'b11, 2'b00);
      pv("unk.fetch",  0, 0, 4'h0, 4'b1001, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("unk.decode", 0, 0, 4'h0, 4'b0000, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("unk.unknown",0, 0, 4'h0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      // STR abandoned by reset in MEMWR
      ctx(4'hE, 2'b01, 6'b011000, 4'd4, 2'b01, 2'b10);
      pv("strr.fetch", 0, 0, 4'h0, 4'b1001, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("strr.decode",0, 0, 4'h0, 4'b0000, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("strr.memadr",0, 0, 4'h0, 4'b0000, 0, 2'b00, 2'b01, 2'b00, 2'b00);
      pv("strr.memwr_rst", 1, 1, 4'h0, 4'b0000, 1, 2'b00, 2'b00, 2'b00, 2'b00);
      ctx(4'hE, 2'b00, 6'b001000, 4'd1, 2'b00, 2'b00);
      pv("post.fetch", 0, 0, 4'h0, 4'b1001, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      cf(4'b0000);
      pv("post.decode",0, 0, 4'h0, 4'b0000, 0, 2'b01, 2'b10, 2'b10, 2'b00);
      pv("post.exec",  0, 0, 4'h0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      pv("post.wb",    0, 0, 4'h0, 4'b0010, 0, 2'b00, 2'b00, 2'b00, 2'b00);

      for (int i = 0; i < vecs.size(); i++) begin
         reset    = vecs[i].rst;
         Cond     = vecs[i].cond;
         Op       = vecs[i].op;
         Funct    = vecs[i].funct;
         Rd       = vecs[i].rd;
         ALUFlags = vecs[i].af;
         @(negedge clk);
         got = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
                ResultSrc, ALUControl, ImmSrc, RegSrc};
         checks++;
         if ((got & vecs[i].mask) !== (vecs[i].exp & vecs[i].mask)) begin
            errors++;
            $display("FAIL %s ctrl got=%b want=%b mask=%b", vecs[i].tag, got,
                     vecs[i].exp, vecs[i].mask);
         end
         if (vecs[i].chk_flags) begin
            checks++;
            if (dut.flags !== vecs[i].exp_flags) begin
               errors++;
               $display("FAIL %s flags got=%b want=%b", vecs[i].tag, dut.flags,
                        vecs[i].exp_flags);
            end
         end
         @(posedge clk);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
